// File: rtl/roi_rgb_mean.sv
// roi_rgb_mean: per-frame RGB565 channel means over a fixed ROI, delivered over valid/ready
module roi_rgb_mean #(
    parameter logic [15:0] ROI_X0     = 16'd0,
    parameter logic [15:0] ROI_Y0     = 16'd0,
    parameter int          ROI_W_LOG2 = 4,
    parameter int          ROI_H_LOG2 = 4
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        cmos_frame_vsync,
    input  logic        cmos_frame_href,
    input  logic        cmos_frame_valid,
    input  logic [15:0] cmos_frame_data,
    output logic        feat_valid,
    input  logic        feat_ready,
    output logic [4:0]  feat_r,
    output logic [5:0]  feat_g,
    output logic [4:0]  feat_b,
    output logic        feat_overrun,
    output logic        roi_busy
);
    localparam int S  = ROI_W_LOG2 + ROI_H_LOG2;
    localparam int RW = 5 + S;
    localparam int GW = 6 + S;
    localparam logic [16:0] X_END = {1'b0, ROI_X0} + 17'(1 << ROI_W_LOG2) - 17'd1;
    localparam logic [16:0] Y_END = {1'b0, ROI_Y0} + 17'(1 << ROI_H_LOG2) - 17'd1;
    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DONE} state_t;
    state_t state, state_nx;
    logic vsync_d, href_d, vs_rise, href_fall, in_roi, last, load;
    logic [15:0] x_cnt, y_cnt;
    logic [RW-1:0] sum_r, sum_b;
    logic [GW-1:0] sum_g;
    assign vs_rise   = cmos_frame_vsync & ~vsync_d;
    assign href_fall = ~cmos_frame_href & href_d;
    assign in_roi    = cmos_frame_valid
                     & ({1'b0, x_cnt} >= {1'b0, ROI_X0}) & ({1'b0, x_cnt} <= X_END)
                     & ({1'b0, y_cnt} >= {1'b0, ROI_Y0}) & ({1'b0, y_cnt} <= Y_END);
    assign last      = in_roi & ({1'b0, x_cnt} == X_END) & ({1'b0, y_cnt} == Y_END);
    assign load      = (state == S_DONE) & (~feat_valid | feat_ready);
    assign roi_busy  = (state == S_FRAME);
    always_ff @(posedge cam_pclk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            state   <= state_nx;
            vsync_d <= cmos_frame_vsync;
            href_d  <= cmos_frame_href;
            x_cnt   <= !cmos_frame_href ? '0 : cmos_frame_valid ? x_cnt + 16'd1 : x_cnt;
            y_cnt   <= vs_rise ? '0 : href_fall ? y_cnt + 16'd1 : y_cnt;
        end
    end
    // A short frame ends in S_FRAME with no result; its vs_rise stays put and restarts.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = vs_rise ? S_FRAME : S_IDLE;
            S_FRAME: state_nx = (last && !vs_rise) ? S_DONE : S_FRAME;
            default: state_nx = vs_rise ? S_FRAME : S_IDLE;
        endcase
    end
    always_ff @(posedge cam_pclk) begin
        if (!rst_n) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (vs_rise) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (roi_busy && in_roi) begin
            sum_r <= sum_r + RW'(cmos_frame_data[15:11]);
            sum_g <= sum_g + GW'(cmos_frame_data[10:5]);
            sum_b <= sum_b + RW'(cmos_frame_data[4:0]);
        end
    end
    always_ff @(posedge cam_pclk) begin
        if (!rst_n) begin
            feat_valid   <= 1'b0;
            feat_r       <= '0;
            feat_g       <= '0;
            feat_b       <= '0;
            feat_overrun <= 1'b0;
        end else begin
            if (load) begin
                feat_r     <= sum_r[S +: 5];
                feat_g     <= sum_g[S +: 6];
                feat_b     <= sum_b[S +: 5];
                feat_valid <= 1'b1;
            end else if (feat_valid && feat_ready) begin
                feat_valid <= 1'b0;
            end
            if (state == S_DONE && !load)
                feat_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_roi_rgb_mean.sv
// tb_roi_rgb_mean: directed frames against hand-computed ROI means, handshake and corner cases
module tb_roi_rgb_mean;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, vs, hr, vl, rdy;
    logic [15:0] d;
    logic fv, fo, busy, fv0, fo0, busy0;
    logic [4:0] fr, fb, fr0, fb0;
    logic [5:0] fg, fg0;
    roi_rgb_mean #(.ROI_X0(16'd2), .ROI_Y0(16'd1), .ROI_W_LOG2(2), .ROI_H_LOG2(2)) dut (
        .cam_pclk(clk), .rst_n(rst_n), .cmos_frame_vsync(vs), .cmos_frame_href(hr),
        .cmos_frame_valid(vl), .cmos_frame_data(d), .feat_valid(fv), .feat_ready(rdy),
        .feat_r(fr), .feat_g(fg), .feat_b(fb), .feat_overrun(fo), .roi_busy(busy));
    roi_rgb_mean #(.ROI_X0(16'd0), .ROI_Y0(16'd0), .ROI_W_LOG2(2), .ROI_H_LOG2(2)) dut0 (
        .cam_pclk(clk), .rst_n(rst_n), .cmos_frame_vsync(vs), .cmos_frame_href(hr),
        .cmos_frame_valid(vl), .cmos_frame_data(d), .feat_valid(fv0), .feat_ready(rdy),
        .feat_r(fr0), .feat_g(fg0), .feat_b(fb0), .feat_overrun(fo0), .roi_busy(busy0));
    int checks = 0, errors = 0, cyc = 0;
    int pulses = 0, pulses0 = 0, rise_cyc = 0, rise0 = 0, last_cyc = 0, last0 = 0;
    logic [4:0] cr, cb, cr0, cb0;
    logic [5:0] cg, cg0;
    logic pv = 1'b0, pv0 = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fv && !pv) begin pulses++; rise_cyc = cyc; cr = fr; cg = fg; cb = fb; end
        if (fv0 && !pv0) begin pulses0++; rise0 = cyc; cr0 = fr0; cg0 = fg0; cb0 = fb0; end
        pv = fv;
        pv0 = fv0;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // mode 0: all white; 1..3: patterns inside the (2,1) ROI; 4: position-coded everywhere
    function automatic logic [15:0] pix(input int mode, input int x, input int y);
        int k = (y - 1) * 4 + (x - 2);
        bit in = (x >= 2) && (x <= 5) && (y >= 1) && (y <= 4);
        case (mode)
            0: return 16'hFFFF;
            1: return in ? {k[4:0], 6'd0, 5'd0} : 16'hFFFF;
            2: return in ? {k[4:0], 6'(2 * k), 5'(31 - k)} : 16'hFFFF;
            3: return in ? 16'h0841 : 16'hFFFF;
            default: return {5'(4 * x + 3), 6'(10 * y), 5'(31 - x - y)};
        endcase
    endfunction
    task automatic step(input logic h, input logic v, input logic [15:0] dd);
        @(posedge clk); #1;
        hr = h; vl = v; d = dd;
    endtask
    task automatic send_frame(input int mode, input int rows, input bit gap, input int rst_row);
        @(posedge clk); #1;
        vs = 1'b1; hr = 1'b0; vl = 1'b0;
        repeat (2) @(posedge clk);
        #1 vs = 1'b0;
        repeat (2) step(1'b0, 1'b0, 16'h0);
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (gap) step(1'b1, 1'b0, 16'h0);
                step(1'b1, 1'b1, pix(mode, x, y));
                if (x == 5 && y == 4) last_cyc = cyc;
                if (x == 3 && y == 3) last0 = cyc;
                if (y == rst_row && x == 3) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1; vl = 1'b0;
                    @(negedge clk);
                    check("rst_valid", fv, 0);
                    check("rst_r", fr, 0);
                    check("rst_g", fg, 0);
                    check("rst_b", fb, 0);
                    check("rst_overrun", fo, 0);
                    check("rst_busy", busy, 0);
                end
            end
            repeat (2) step(1'b0, 1'b0, 16'h0);
        end
        repeat (6) step(1'b0, 1'b0, 16'h0);
    endtask
    typedef struct {int mode; int r; int g; int b;} vec_t;
    vec_t tbl[4];
    initial begin
        tbl[0] = '{0, 31, 63, 31};
        tbl[1] = '{1, 7, 0, 0};
        tbl[2] = '{2, 7, 15, 23};
        tbl[3] = '{3, 1, 2, 1};
        rst_n = 1'b0; vs = 1'b0; hr = 1'b0; vl = 1'b0; d = 16'h0; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_valid", fv, 0);
        check("reset_r", fr, 0);
        check("reset_g", fg, 0);
        check("reset_b", fb, 0);
        check("reset_overrun", fo, 0);
        check("reset_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            pulses = 0;
            send_frame(tbl[i].mode, 6, 1'b0, -1);
            check("tbl_pulses", pulses, 1);
            check("tbl_latency", rise_cyc - last_cyc, 2);
            check("tbl_r", cr, tbl[i].r);
            check("tbl_g", cg, tbl[i].g);
            check("tbl_b", cb, tbl[i].b);
            check("tbl_valid_cleared", fv, 0);
        end
        rdy = 1'b0;
        send_frame(2, 6, 1'b0, -1);
        send_frame(0, 6, 1'b0, -1);
        @(negedge clk);
        check("ovr_valid", fv, 1);
        check("ovr_r", fr, 7);
        check("ovr_g", fg, 15);
        check("ovr_b", fb, 23);
        check("ovr_flag", fo, 1);
        @(posedge clk); #1 rdy = 1'b1;
        @(negedge clk);
        check("ovr_valid_held", fv, 1);
        @(negedge clk);
        check("ovr_valid_drop", fv, 0);
        check("ovr_sticky", fo, 1);
        pulses = 0;
        send_frame(0, 3, 1'b0, -1);
        check("short_pulses", pulses, 0);
        check("short_busy", busy, 1);
        send_frame(3, 6, 1'b0, -1);
        check("after_short_pulses", pulses, 1);
        check("after_short_r", cr, 1);
        check("after_short_g", cg, 2);
        check("after_short_b", cb, 1);
        pulses = 0;
        send_frame(0, 6, 1'b0, 2);
        check("post_rst_pulses", pulses, 0);
        check("post_rst_busy", busy, 0);
        send_frame(2, 6, 1'b0, -1);
        check("rst_frame_pulses", pulses, 1);
        check("rst_frame_r", cr, 7);
        check("rst_frame_g", cg, 15);
        check("rst_frame_b", cb, 23);
        pulses0 = 0;
        send_frame(4, 6, 1'b1, -1);
        check("gap_pulses", pulses0, 1);
        check("gap_latency", rise0 - last0, 2);
        check("gap_r", cr0, 9);
        check("gap_g", cg0, 15);
        check("gap_b", cb0, 28);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/roi_rgb_mean.md
Name: roi_rgb_mean

Overview:
- Consumes the RGB565 pixel stream (frame vsync, line href, pixel-valid strobe, 16-bit data) from the camera capture stage.
- Accumulates R, G and B over a fixed rectangular region of interest (ROI) once per frame.
- Emits per-frame channel means as a feature vector over a valid/ready handshake to the downstream decision-tree classifier.
- Runs entirely in the camera pixel clock domain.

Parameters:
- ROI_X0, 16'd0: first ROI column, counted in valid pixels per line from 0.
- ROI_Y0, 16'd0: first ROI row, counted in lines per frame from 0.
- ROI_W_LOG2, 4: ROI width is 2^ROI_W_LOG2 pixels (valid range 0..10).
- ROI_H_LOG2, 4: ROI height is 2^ROI_H_LOG2 lines (valid range 0..10).

Ports:
- cam_pclk, input, 1: pixel clock; the only clock.
- rst_n, input, 1: reset, synchronous, active-low.
- cmos_frame_vsync, input, 1: frame sync; a rising edge marks frame start.
- cmos_frame_href, input, 1: line active.
- cmos_frame_valid, input, 1: one-cycle strobe; cmos_frame_data is a valid pixel this cycle.
- cmos_frame_data, input, 16: RGB565 pixel. R=[15:11], G=[10:5], B=[4:0].
- feat_valid, output, 1: feature vector available.
- feat_ready, input, 1: consumer accepts the vector.
- feat_r, output, 5: mean R.
- feat_g, output, 6: mean G.
- feat_b, output, 5: mean B.
- feat_overrun, output, 1: sticky flag; a completed result was dropped.
- roi_busy, output, 1: high while in S_FRAME.

Behaviour:
- All flops update on posedge cam_pclk. When rst_n=0 at a clock edge:
  - state=S_IDLE.
  - All counters and accumulators = 0.
  - feat_valid=0, feat_r/g/b=0, feat_overrun=0, roi_busy=0.
  - Reset asserted mid-frame or mid-handshake discards everything.
- vsync_d registers cmos_frame_vsync. vs_rise = vsync & ~vsync_d. href_d is handled the same way; href_fall = ~href & href_d.
- x_cnt (16b): increments on each cmos_frame_valid while href=1. Clears on the cycle href=0.
- y_cnt (16b): increments on href_fall. Clears on vs_rise.
- in_roi = valid & (x_cnt in [ROI_X0, ROI_X0+2^W-1]) & (y_cnt in [ROI_Y0, ROI_Y0+2^H-1]). Compare with current counter values, before the increment.
- Accumulator widths:
  - sum_r: 5+W+H bits.
  - sum_g: 6+W+H bits.
  - sum_b: 5+W+H bits.
  - No overflow is possible by construction.
- State S_IDLE:
  - On vs_rise: clear sums, go to S_FRAME.
  - Pixels arriving while in S_IDLE are ignored. The first frame after reset starts at the first vs_rise.
- State S_FRAME (roi_busy=1):
  - On in_roi: add the three channels to their sums.
  - On the cycle accumulating the last ROI pixel (x=ROI_X0+2^W-1, y=ROI_Y0+2^H-1): include it, then go to S_DONE next cycle.
  - On vs_rise before the ROI completes (short frame): clear sums, stay in S_FRAME, produce no result. That vs_rise starts the new frame.
- State S_DONE (exactly 1 cycle):
  - Means = sum >> (W+H), truncating.
  - If feat_valid=0, or feat_valid & feat_ready this cycle: load feat_r/g/b and set feat_valid=1.
  - Otherwise keep the old vector and set feat_overrun=1.
  - Go to S_IDLE.
- Latency: feat_valid rises 2 cycles after the cycle the last ROI pixel is presented.
- Handshake:
  - feat_valid clears on the cycle after feat_valid & feat_ready, unless S_DONE reloads it in that same cycle.
  - feat_r/g/b are stable while feat_valid=1 and not yet accepted.
- feat_overrun clears only on reset.
- vs_rise in S_DONE is taken as the next frame's start: transition to S_FRAME with sums cleared, after the result is latched.
- An ROI lying outside the frame never completes. The block stays in S_FRAME and produces no output.

Test Plan:
- Reset, then 8x6 frames, ROI_X0=2, ROI_Y0=1, W_LOG2=H_LOG2=2, every pixel 16'hFFFF, feat_ready=1 -> feat_r=31, feat_g=63, feat_b=31, one feat_valid pulse per frame, exactly 2 cycles after pixel (5,4).
- Same ROI; in-ROI pixel k (k=0..15) = {k[4:0], 6'd0, 5'd0}, others 16'hFFFF -> feat_r=7 (sum 120>>4), feat_g=0, feat_b=0. Proves out-of-ROI pixels are excluded.
- feat_ready=0 across two full frames with distinct data -> first vector held unchanged, feat_overrun=1. Then feat_ready=1 -> feat_valid drops one cycle later.
- vsync rises when only row y=2 of the ROI is complete -> no feat_valid for that frame. The next full frame's result is computed from that frame only.
- rst_n=0 for one cycle mid-ROI -> all outputs 0 next cycle. Pixels before the following vsync are ignored, and the following full frame yields the correct mean.
- Interleave href gaps and valid strobes every other cycle (byte pairing), ROI at ROI_X0=0, ROI_Y0=0 corner -> x/y counting correct, result matches the reference mean.
